instr_encoder: RTL and testbench

- Pipelined RV32I instruction encoder: the inverse of the immediate decoder in the decode stage.
- Accepts opcode, register fields, funct fields and a 32-bit signed immediate, and packs them into a 32-bit instruction word.
- Range-checks the immediate against the format's encodable range.
- Emits each word with a sequential write address, feeding the instruction-memory boot loader and the self-test program generator.
- Valid/ready on both sides; 2-stage pipeline.

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into a
// 32-bit word, range-checks the immediate, and emits words with sequential addresses.
module instr_encoder #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [31:0]       NOP_WORD  = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic              out_err,
   output logic [ADDR_W-1:0] out_addr,
   output logic [7:0]        err_count
);

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ERR
   } fmt_e;

   fmt_e        fmt_d, s1_fmt_q;
   logic [31:0] word_d, s1_word_q;
   logic        range_err_d, s1_range_err_q;
   logic        s1_valid_q;

   logic              out_valid_q, out_err_q;
   logic [31:0]       out_instr_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [7:0]        err_count_q;

   logic        s1_load, s2_load, xfer;
   logic        s2_err_d;
   logic [31:0] s2_instr_d;

   // True when every bit of the slice equals its neighbours (a clean sign extension).
   function automatic logic all_same(input logic [31:0] v, input int lsb);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << lsb;
      return ((v & m) == m) || ((v & m) == 32'h0);
   endfunction

   // NOTE: every always_comb output gets a default first, so no path leaves a latch.
   always_comb begin
      fmt_d       = FMT_ERR;
      word_d      = '0;
      range_err_d = 1'b0;
      unique case (in_opcode)
         7'b0110011:             fmt_d = FMT_R;
         7'b0010011, 7'b0000011: fmt_d = FMT_I;
         7'b0100011:             fmt_d = FMT_S;
         7'b1100011:             fmt_d = FMT_B;
         7'b0110111:             fmt_d = FMT_U;
         7'b1101111:             fmt_d = FMT_J;
         default:                fmt_d = FMT_ERR;
      endcase
      case (fmt_d)
         FMT_R: word_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: begin
            word_d      = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            range_err_d = !all_same(in_imm, 11);
         end
         FMT_S: begin
            word_d      = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            range_err_d = !all_same(in_imm, 11);
         end
         FMT_B: begin
            word_d      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            range_err_d = in_imm[0] || !all_same(in_imm, 12);
         end
         FMT_U: begin
            word_d      = {in_imm[31:12], in_rd, in_opcode};
            range_err_d = |in_imm[11:0];
         end
         FMT_J: begin
            word_d      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            range_err_d = in_imm[0] || !all_same(in_imm, 20);
         end
         default: word_d = '0;
      endcase
   end

   assign xfer     = out_valid_q && out_ready;
   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   assign s2_err_d   = s1_range_err_q || (s1_fmt_q == FMT_ERR);
   assign s2_instr_d = s2_err_d ? NOP_WORD : s1_word_q;

   // NOTE: the stage-1 payload is qualified by s1_valid_q, so only the valid bit needs reset.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_fmt_q       <= fmt_d;
         s1_word_q      <= word_d;
         s1_range_err_q <= range_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_err_q   <= 1'b0;
         out_addr_q  <= BASE_ADDR;
         err_count_q <= '0;
      end else begin
         s1_valid_q <= s1_load || (s1_valid_q && !s2_load);
         if (s2_load) begin
            out_valid_q <= 1'b1;
            out_instr_q <= s2_instr_d;
            out_err_q   <= s2_err_d;
         end else if (xfer) begin
            out_valid_q <= 1'b0;
         end
         if (xfer) begin
            out_addr_q <= out_addr_q + 1'b1;
            if (out_err_q && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign out_addr  = out_addr_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, backpressure,
// address wrap (2-bit instance), error saturation and mid-flight reset.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm, out_instr;
   logic [7:0]  out_addr, err_count;

   logic        w_in_ready, w_out_valid, w_out_err;
   logic [31:0] w_out_instr;
   logic [1:0]  w_out_addr;
   logic [7:0]  w_err_count;

   instr_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .out_addr(out_addr), .err_count(err_count)
   );

   instr_encoder #(.ADDR_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
      .out_err(w_out_err), .out_addr(w_out_addr), .err_count(w_err_count)
   );

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   vec_t        vecs[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_addr = 0;
   logic [31:0] exp_errs = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic add(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
      vec_t v;
      v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
      v.imm = imm; v.exp_instr = exp_instr; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
   endtask

   // Streams vecs through the DUT; out_ready held low for the first `stall` cycles.
   // Entered and left 1 time unit after a rising edge.
   task automatic run_stream(input int stall, input bit check_tput);
      int n = vecs.size();
      int k = 0;
      int m = 0;
      int c = 0;
      logic rdy;
      while (m < n && c < 3 * n + 20) begin
         in_valid = (k < n);
         if (k < n) drive(vecs[k]);
         out_ready = (c >= stall);
         @(negedge clk);
         rdy = in_ready;
         if (stall >= 4 && c == stall - 1) begin
            check("bp_accepted", k, 2);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         end
         if (out_valid && !out_ready)
            check("hold_instr", out_instr, vecs[m].exp_instr);
         if (out_valid && out_ready) begin
            check("instr", out_instr, vecs[m].exp_instr);
            check("err", {31'b0, out_err}, {31'b0, vecs[m].exp_err});
            check("addr", {24'b0, out_addr}, exp_addr & 32'hFF);
            check("addr_w", {30'b0, w_out_addr}, exp_addr & 32'h3);
            check("err_count", {24'b0, err_count}, exp_errs);
            exp_addr = exp_addr + 1;
            if (vecs[m].exp_err && exp_errs != 255) exp_errs = exp_errs + 1;
            m++;
         end
         if (in_valid && rdy) k++;
         c++;
         @(posedge clk);
         #1;
      end
      check("stream_done", m, n);
      if (check_tput) check("throughput_cycles", c, n + 2);
      in_valid = 1'b0;
      vecs.delete();
   endtask

   initial begin
      vec_t addi5;
      in_valid = 0; out_ready = 0;
      in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
      in_funct3 = 0; in_funct7 = 0; in_imm = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err", {31'b0, out_err}, 32'd0);
      check("rst_out_addr", {24'b0, out_addr}, 32'd0);
      check("rst_err_count", {24'b0, err_count}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // ADDI x1,x0,5: latency of two edges from the accepting cycle.
      addi5.op = 7'b0010011; addi5.rd = 1; addi5.rs1 = 0; addi5.rs2 = 0;
      addi5.f3 = 0; addi5.f7 = 0; addi5.imm = 5; addi5.exp_instr = 32'h0050_0093; addi5.exp_err = 0;
      @(posedge clk); #1;
      drive(addi5); in_valid = 1; out_ready = 1;
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      check("lat_not_yet", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_valid", {31'b0, out_valid}, 32'd1);
      check("addi_instr", out_instr, 32'h0050_0093);
      check("addi_err", {31'b0, out_err}, 32'd0);
      check("addi_addr", {24'b0, out_addr}, 32'd0);
      exp_addr = 1;
      @(posedge clk); #1;

      // Back-to-back directed encodings at full throughput.
      add(7'b0100011, 0, 1, 2, 3'd2, 0, 32'd8,          32'h0020_A423, 0); // SW x2,8(x1)
      add(7'b1100011, 0, 1, 2, 3'd0, 0, -32'sd4,        32'hFE20_8EE3, 0); // BEQ x1,x2,-4
      add(7'b1101111, 1, 0, 0, 3'd0, 0, 32'd2048,       32'h0010_00EF, 0); // JAL x1,2048
      add(7'b0110111, 5, 0, 0, 3'd0, 0, 32'h1234_5000,  32'h1234_52B7, 0); // LUI x5
      add(7'b0110111, 5, 0, 0, 3'd0, 0, 32'h1234_5001,  NOP,           1); // LUI low bits set
      add(7'b0110011, 3, 1, 2, 3'd0, 7'h00, 32'd0,      32'h0020_81B3, 0); // ADD x3,x1,x2
      add(7'b0110011, 3, 1, 2, 3'd0, 7'h20, 32'hDEAD,   32'h4020_81B3, 0); // SUB, imm ignored
      add(7'b0010011, 1, 0, 0, 3'd0, 0, 32'd2048,       NOP,           1); // ADDI out of range
      add(7'b0010011, 1, 0, 0, 3'd0, 0, 32'd2047,       32'h7FF0_0093, 0); // ADDI max
      add(7'b0010011, 1, 0, 0, 3'd0, 0, -32'sd2048,     32'h8000_0093, 0); // ADDI min
      add(7'b0010011, 1, 0, 0, 3'd0, 0, -32'sd2049,     NOP,           1); // ADDI below min
      add(7'b0000011, 4, 2, 0, 3'd2, 0, 32'd4,          32'h0041_2203, 0); // LW x4,4(x2)
      add(7'b1100011, 0, 1, 2, 3'd0, 0, 32'd3,          NOP,           1); // BEQ odd offset
      add(7'b1101111, 0, 0, 0, 3'd0, 0, 32'hFFF0_0000,  32'h8000_006F, 0); // JAL min offset
      add(7'b1101111, 0, 0, 0, 3'd0, 0, 32'h0010_0000,  NOP,           1); // JAL out of range
      add(7'b1111111, 1, 2, 3, 3'd0, 0, 32'd0,          NOP,           1); // illegal opcode
      run_stream(0, 1'b1);

      // Backpressure: four offered words, only two fit while out_ready is low.
      for (int i = 1; i <= 4; i++)
         add(7'b0010011, 1, 0, 0, 3'd0, 0, i, (i << 20) | 32'h93, 0);
      run_stream(6, 1'b0);

      // Error saturation.
      for (int i = 0; i < 300; i++)
         add(7'b1111111, 0, 0, 0, 3'd0, 0, i, NOP, 1);
      run_stream(0, 1'b1);
      check("err_count_sat", {24'b0, err_count}, 32'd255);

      // Mid-flight reset with both stages full.
      drive(addi5); in_valid = 1; out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("full_out_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1 rst = 1; in_valid = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mrst_out_addr", {24'b0, out_addr}, 32'd0);
      check("mrst_err_count", {24'b0, err_count}, 32'd0);
      check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("mrst_w_out_valid", {31'b0, w_out_valid}, 32'd0);
      exp_addr = 0; exp_errs = 0;
      @(posedge clk); #1;

      // Wrap: 2-bit instance must show 0,1,2,3,0.
      for (int i = 0; i < 5; i++)
         add(7'b0010011, 2, 1, 0, 3'd0, 0, i, (i << 20) | (1 << 15) | (2 << 7) | 32'h13, 0);
      run_stream(0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
